// File: rtl/ps2_key_status.sv
// ---------------------------------------------------------------------------
// ps2_key_status
//   PS/2 keyboard receiver (scan-code set 2) with a make/break decoder.
//   It keeps a 10-bit "key currently held" vector for the servo data
//   controller. Bit map: 0=W 1=S 2=A 3=D 4=I 5=K 6=J 7=L 8=SPACE 9=ENTER.
//   Everything runs in the i_clk domain. The raw PS/2 lines are synchronised
//   on entry.
//
// Parameters
//   TIMEOUT_CYCLES    i_clk cycles without a PS/2 clock fall mid-frame
//                     before the partial frame is aborted
//
// Optional feature macro
//   PS2_PARITY_CHECK_EN  when defined, odd parity is enforced; otherwise the
//                        parity bit is captured but not checked
//
// Ports
//   i_clk              system clock
//   i_rst_n            asynchronous active-low reset
//   i_ps2_clk          raw PS/2 clock (asynchronous)
//   i_ps2_data         raw PS/2 data (asynchronous)
//   o_keyboard_status  held-key vector
//   o_scan_code        last correctly framed byte
//   o_code_valid       1-cycle pulse, o_scan_code updated
//   o_frame_err        1-cycle pulse, frame rejected (framing/parity/timeout)
// ---------------------------------------------------------------------------
module ps2_key_status #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [9:0] o_keyboard_status,
    output logic [7:0] o_scan_code,
    output logic       o_code_valid,
    output logic       o_frame_err
);

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_EXT,
        ST_EXT_BREAK
    } state_t;

    logic          r_clk_s1, r_clk_s2, r_clk_prev;
    logic          r_data_s1, r_data_s2;
    logic [10:0]   r_shift;
    logic [3:0]    r_bit_cnt;
    logic [IW-1:0] r_idle_cnt;
    logic [7:0]    r_scan_code;
    logic          r_code_valid;
    logic          r_frame_err;
    logic [9:0]    r_status;
    state_t        r_state;

    logic          w_fall;
    logic          w_parity_ok;
    logic          w_frame_ok;
    logic          w_mid_frame;
    logic [7:0]    w_byte;
    logic [9:0]    w_key_mask;
    logic          w_key_hit;
    state_t        w_state_next;
    logic [9:0]    w_status_next;

    // The previous synchronised clock sample gives the falling-edge detector.
    assign w_fall      = r_clk_prev & ~r_clk_s2;
    // Frame layout after 11 LSB-first shifts:
    // [0]=start, [8:1]=data, [9]=parity, [10]=stop.
    assign w_byte      = r_shift[8:1];
    assign w_parity_ok = ^r_shift[9:1];   // odd parity -> XOR of all nine bits is 1
    assign w_mid_frame = (r_bit_cnt >= 4'd1) && (r_bit_cnt <= 4'd10);

`ifdef PS2_PARITY_CHECK_EN
    assign w_frame_ok = ~r_shift[0] & r_shift[10] & w_parity_ok;
`else
    // The parity bit is captured but not enforced. OR-ing with 1 keeps it
    // referenced without giving it any effect on the result.
    assign w_frame_ok = ~r_shift[0] & r_shift[10] & (w_parity_ok | 1'b1);
`endif

    // ---------------- synchroniser, receiver, timeout ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_clk_prev   <= 1'b1;
            r_data_s1    <= 1'b1;
            r_data_s2    <= 1'b1;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_idle_cnt   <= '0;
            r_scan_code  <= '0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_clk_s1     <= i_ps2_clk;
            r_clk_s2     <= r_clk_s1;
            r_clk_prev   <= r_clk_s2;
            r_data_s1    <= i_ps2_data;
            r_data_s2    <= r_data_s1;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            if (r_bit_cnt == 4'd11) begin
                // Check cycle: the eleventh edge has been seen.
                r_bit_cnt  <= '0;
                r_idle_cnt <= '0;
                if (w_frame_ok) begin
                    r_scan_code  <= w_byte;
                    r_code_valid <= 1'b1;
                end else begin
                    r_frame_err  <= 1'b1;
                end
            end else if (w_fall) begin
                r_shift    <= {r_data_s2, r_shift[10:1]};
                r_bit_cnt  <= r_bit_cnt + 4'd1;
                r_idle_cnt <= '0;
            end else if (w_mid_frame) begin
                if (r_idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
                    r_bit_cnt   <= '0;
                    r_idle_cnt  <= '0;
                    r_frame_err <= 1'b1;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

    // ---------------- make/break decoder ----------------
    always_comb begin
        w_key_mask = '0;
        case (r_scan_code)
            8'h1D:   w_key_mask = 10'h001;  // W
            8'h1B:   w_key_mask = 10'h002;  // S
            8'h1C:   w_key_mask = 10'h004;  // A
            8'h23:   w_key_mask = 10'h008;  // D
            8'h43:   w_key_mask = 10'h010;  // I
            8'h42:   w_key_mask = 10'h020;  // K
            8'h3B:   w_key_mask = 10'h040;  // J
            8'h4B:   w_key_mask = 10'h080;  // L
            8'h29:   w_key_mask = 10'h100;  // SPACE
            8'h5A:   w_key_mask = 10'h200;  // ENTER
            default: w_key_mask = '0;
        endcase
    end

    assign w_key_hit = |w_key_mask;

    always_comb begin
        w_state_next  = r_state;
        w_status_next = r_status;
        if (r_code_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_scan_code == 8'hF0)      w_state_next = ST_BREAK;
                    else if (r_scan_code == 8'hE0) w_state_next = ST_EXT;
                    else                           w_status_next = r_status | w_key_mask;
                end
                ST_BREAK: begin
                    if (w_key_hit) begin
                        w_status_next = r_status & ~w_key_mask;
                        w_state_next  = ST_IDLE;
                    end else if (r_scan_code == 8'hE0) begin
                        w_state_next = ST_EXT_BREAK;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                // Extended keys are ignored; only the E0 F0 prefix needs tracking.
                ST_EXT: begin
                    if (r_scan_code == 8'hF0) w_state_next = ST_EXT_BREAK;
                    else                      w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_status <= '0;
        end else begin
            r_state  <= w_state_next;
            r_status <= w_status_next;
        end
    end

    assign o_keyboard_status = r_status;
    assign o_scan_code       = r_scan_code;
    assign o_code_valid      = r_code_valid;
    assign o_frame_err       = r_frame_err;

endmodule

// File: tb/tb_ps2_key_status.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_status
//   Table-driven bench for ps2_key_status. It also has hand-written
//   sequences for the mid-frame reset and timeout corner cases. The PS/2
//   device is modelled bit by bit. Pulses are counted on the falling edge of
//   clk.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_key_status;

    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [9:0] status;
    logic [7:0] scan;
    logic       valid;
    logic       ferr;

    ps2_key_status #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_ps2_clk         (ps2_clk),
        .i_ps2_data        (ps2_data),
        .o_keyboard_status (status),
        .o_scan_code       (scan),
        .o_code_valid      (valid),
        .o_frame_err       (ferr)
    );

    always #5 clk = ~clk;

    int n_valid = 0;
    int n_err   = 0;
    always @(negedge clk) begin
        if (valid) n_valid++;
        if (ferr)  n_err++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        logic par;
        par = (~^d) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            wait_cyc(10);
            ps2_clk = 1'b0;
            wait_cyc(20);
            ps2_clk = 1'b1;
            wait_cyc(10);
        end
    endtask

    task automatic send_frame(input logic [10:0] f);
        send_bits(f, 11);
        ps2_data = 1'b1;
        wait_cyc(20);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       bad_stop;
        logic [9:0] exp_status;
        logic [7:0] exp_scan;
        int         exp_valid;
        int         exp_err;
    } vec_t;

    vec_t vec[32];
    int   n_vec = 0;

    task automatic add(input logic [7:0] d, input logic bp, input logic bs,
                       input logic [9:0] st, input logic [7:0] sc, input int v, input int e);
        vec[n_vec].data       = d;
        vec[n_vec].bad_par    = bp;
        vec[n_vec].bad_stop   = bs;
        vec[n_vec].exp_status = st;
        vec[n_vec].exp_scan   = sc;
        vec[n_vec].exp_valid  = v;
        vec[n_vec].exp_err    = e;
        n_vec++;
    endtask

    initial begin
        logic [9:0] st_par;
        logic [7:0] sc_par;
        int         v0, e0;

        // ---------------- vector table ----------------
        add(8'h1D, 0, 0, 10'h001, 8'h1D, 1, 0);  // W make
        add(8'hF0, 0, 0, 10'h001, 8'hF0, 1, 0);  // F0 alone: no change
        add(8'h1D, 0, 0, 10'h000, 8'h1D, 1, 0);  // W break
        add(8'hF0, 0, 0, 10'h000, 8'hF0, 1, 0);
        add(8'h33, 0, 0, 10'h000, 8'h33, 1, 0);  // break of unmapped key
        add(8'h1D, 0, 0, 10'h001, 8'h1D, 1, 0);  // hold W
        add(8'h5A, 0, 0, 10'h201, 8'h5A, 1, 0);  // ENTER
        add(8'hE0, 0, 0, 10'h201, 8'hE0, 1, 0);
        add(8'h5A, 0, 0, 10'h201, 8'h5A, 1, 0);  // E0 5A ignored
        add(8'hE0, 0, 0, 10'h201, 8'hE0, 1, 0);
        add(8'hF0, 0, 0, 10'h201, 8'hF0, 1, 0);
        add(8'h5A, 0, 0, 10'h201, 8'h5A, 1, 0);  // E0 F0 5A ignored
        add(8'h1D, 0, 0, 10'h201, 8'h1D, 1, 0);  // typematic repeat
        add(8'hF0, 0, 0, 10'h201, 8'hF0, 1, 0);
        add(8'h5A, 0, 0, 10'h001, 8'h5A, 1, 0);
        add(8'hF0, 0, 0, 10'h001, 8'hF0, 1, 0);
        add(8'h1D, 0, 0, 10'h000, 8'h1D, 1, 0);
`ifdef PS2_PARITY_CHECK_EN
        st_par = 10'h000; sc_par = 8'h1D;
        add(8'h1B, 1, 0, st_par, sc_par, 0, 1);  // bad parity rejected
`else
        st_par = 10'h002; sc_par = 8'h1B;
        add(8'h1B, 1, 0, st_par, sc_par, 1, 0);  // bad parity ignored
`endif
        add(8'h1C, 0, 1, st_par, sc_par, 0, 1);  // bad stop bit always rejected
        add(8'hF0, 0, 0, st_par, 8'hF0, 1, 0);
        add(8'h1B, 0, 0, 10'h000, 8'h1B, 1, 0);
        add(8'h1C, 0, 0, 10'h004, 8'h1C, 1, 0);  // several keys held
        add(8'h23, 0, 0, 10'h00C, 8'h23, 1, 0);
        add(8'h29, 0, 0, 10'h10C, 8'h29, 1, 0);

        // ---------------- reset state ----------------
        wait_cyc(5);
        @(negedge clk);
        check("reset_status", int'(status), 0);
        check("reset_scan",   int'(scan),   0);
        check("reset_valid",  int'(valid),  0);
        check("reset_err",    int'(ferr),   0);
        rst_n = 1'b1;
        wait_cyc(10);

        // ---------------- table ----------------
        for (int i = 0; i < n_vec; i++) begin
            v0 = n_valid; e0 = n_err;
            send_frame(mk(vec[i].data, vec[i].bad_par, vec[i].bad_stop));
            @(negedge clk);
            check($sformatf("v%0d_status", i), int'(status), int'(vec[i].exp_status));
            check($sformatf("v%0d_scan",   i), int'(scan),   int'(vec[i].exp_scan));
            check($sformatf("v%0d_valid",  i), n_valid - v0, vec[i].exp_valid);
            check($sformatf("v%0d_err",    i), n_err - e0,   vec[i].exp_err);
            $display("vec %0d: byte=%02h bp=%0d bs=%0d status=%03h scan=%02h",
                     i, vec[i].data, vec[i].bad_par, vec[i].bad_stop, status, scan);
        end

        // ---------------- reset mid-frame with W held ----------------
        send_frame(mk(8'h1D, 0, 0));
        @(negedge clk);
        check("hold_w_status", int'(status), 'h10D);
        v0 = n_valid; e0 = n_err;
        send_bits(mk(8'h42, 0, 0), 6);
        rst_n = 1'b0;
        wait_cyc(5);
        @(negedge clk);
        check("midrst_status", int'(status), 0);
        check("midrst_scan",   int'(scan),   0);
        ps2_data = 1'b1;
        rst_n = 1'b1;
        wait_cyc(20);
        check("midrst_valid_pulses", n_valid - v0, 0);
        check("midrst_err_pulses",   n_err - e0,   0);
        v0 = n_valid;
        send_frame(mk(8'h29, 0, 0));
        @(negedge clk);
        check("post_rst_status", int'(status), 'h100);
        check("post_rst_scan",   int'(scan),   'h29);
        check("post_rst_valid",  n_valid - v0, 1);
        $display("midrst: status=%03h scan=%02h", status, scan);

        // ---------------- timeout ----------------
        v0 = n_valid; e0 = n_err;
        send_bits(mk(8'h44, 0, 0), 5);
        ps2_data = 1'b1;
        wait_cyc(TO - 60);
        check("to_early_err", n_err - e0, 0);
        wait_cyc(100);
        check("to_err",    n_err - e0,   1);
        check("to_valid",  n_valid - v0, 0);
        check("to_status", int'(status), 'h100);
        v0 = n_valid;
        send_frame(mk(8'h23, 0, 0));
        @(negedge clk);
        check("post_to_status", int'(status), 'h108);
        check("post_to_scan",   int'(scan),   'h23);
        check("post_to_valid",  n_valid - v0, 1);
        $display("timeout: status=%03h scan=%02h", status, scan);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
